// File: rtl/sr_ff_excite_ctrl_pkg.sv
// Shared definitions for the SR flip-flop excitation controller: FSM encoding,
// retry counter sizing and the width of the optional SR_EXCITE_STATS_EN counter.
package sr_excite_pkg;

  typedef logic [1:0] sr_state_t;

  localparam sr_state_t ST_IDLE  = 2'd0;
  localparam sr_state_t ST_DRIVE = 2'd1;
  localparam sr_state_t ST_WAIT  = 2'd2;
  localparam sr_state_t ST_CHECK = 2'd3;

  localparam int STATS_W = 8;

  // Retry counter must hold 0..max_retry; a zero-retry build still needs one bit.
  function automatic int retry_width(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_ff_excite_ctrl_if.sv
// Request handshake between control logic and the SR excitation controller.
interface sr_ff_excite_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;

  modport master (output req_valid, output req_target, input req_ready);
  modport slave  (input req_valid, input req_target, output req_ready);
endinterface

// File: rtl/sr_ff_excite_ctrl_calc.sv
// Per-bit SR excitation: set where Q must rise, reset where Q must fall, never both.
module sr_excite_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);
  assign s = tgt & ~q;
  assign r = ~tgt & q;
endmodule

// File: rtl/sr_ff_excite_ctrl.sv
// Write-side controller for a bank of SR flip-flops: drive, settle, verify, retry.
// Optional SR_EXCITE_STATS_EN adds the saturating retry_total output.
module sr_ff_excite_ctrl
  import sr_excite_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int SETTLE    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_ff_excite_ctrl_if.slave   req,
  input  logic [WIDTH-1:0]     q_fb,
  output logic [WIDTH-1:0]     s_out,
  output logic [WIDTH-1:0]     r_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef SR_EXCITE_STATS_EN
  ,
  output logic [STATS_W-1:0]   retry_total
`endif
);

  localparam int RW = retry_width(MAX_RETRY);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  sr_state_t        state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
  logic             done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [WIDTH-1:0] calc_tgt_s, calc_s_s, calc_r_s;

  // In IDLE the excitation is computed from the incoming target, later from the latched one.
  assign calc_tgt_s = (state_q == ST_IDLE) ? req.req_target : tgt_q;

  sr_excite_calc #(.WIDTH(WIDTH)) u_calc (
    .tgt (calc_tgt_s),
    .q   (q_fb),
    .s   (calc_s_s),
    .r   (calc_r_s)
  );

  // Next-state logic; S/R default to zero so they are only non-zero during DRIVE.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    s_d      = {WIDTH{1'b0}};
    r_d      = {WIDTH{1'b0}};
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          state_d = ST_DRIVE;
          tgt_d   = req.req_target;
          retry_d = {RW{1'b0}};
          s_d     = calc_s_s;
          r_d     = calc_r_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_d  = ST_WAIT;
        settle_d = SETTLE_LD;
      end
      ST_WAIT: begin
        if (settle_q <= SW'(1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          state_d = ST_DRIVE;
          s_d     = calc_s_s;
          r_d     = calc_r_s;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tgt_q    <= {WIDTH{1'b0}};
      retry_q  <= {RW{1'b0}};
      settle_q <= {SW{1'b0}};
      s_q      <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign s_out         = s_q;
  assign r_out         = r_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign req.req_ready = (state_q == ST_IDLE);

`ifdef SR_EXCITE_STATS_EN
  logic               retry_inc_s;
  logic [STATS_W-1:0] retry_total_q;

  assign retry_inc_s = (state_q == ST_CHECK) && (state_d == ST_DRIVE);

  // Lifetime count of retry drives, saturating; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_total_q <= {STATS_W{1'b0}};
    end else if (retry_inc_s && (retry_total_q != {STATS_W{1'b1}})) begin
      retry_total_q <= retry_total_q + STATS_W'(1);
    end else begin
      retry_total_q <= retry_total_q;
    end
  end

  assign retry_total = retry_total_q;
`endif

endmodule

// File: tb/tb_sr_ff_excite_ctrl.sv
// Directed bench for sr_ff_excite_ctrl driving a behavioural 8-bit SR flip-flop bank.
module tb_sr_ff_excite_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] q_fb, s_out, r_out;
  logic       busy, done, err;
  logic [7:0] bank_q;
  logic       bank_ld = 1'b0;
  logic [7:0] bank_ld_val = 8'h00;
  logic [7:0] stuck0 = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
`ifdef SR_EXCITE_STATS_EN
  logic [7:0] retry_total;
`endif

  sr_ff_excite_ctrl_if #(.WIDTH(8)) req_if ();

  sr_ff_excite_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_if),
    .q_fb  (q_fb),
    .s_out (s_out),
    .r_out (r_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef SR_EXCITE_STATS_EN
    ,
    .retry_total (retry_total)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SR bank; stuck0 forces selected readback bits low.
  always @(posedge clk) begin
    if (bank_ld) bank_q <= bank_ld_val;
    else         bank_q <= (bank_q & ~r_out) | s_out;
  end
  assign q_fb = bank_q & ~stuck0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // S and R must never be asserted together on any bit.
  always @(negedge clk) chk("s_and_r_exclusive", {24'h0, s_out & r_out}, 32'h0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    bank_ld     = 1'b1;
    bank_ld_val = v;
    step();
    bank_ld = 1'b0;
  endtask

  task automatic run_req(input logic [7:0] tgt, input logic [7:0] es, input logic [7:0] er);
    req_if.req_valid  = 1'b1;
    req_if.req_target = tgt;
    step();
    chk("drive_s", {24'h0, s_out}, {24'h0, es});
    chk("drive_r", {24'h0, r_out}, {24'h0, er});
    chk("drive_busy", {31'h0, busy}, 32'h1);
    chk("drive_ready", {31'h0, req_if.req_ready}, 32'h0);
    req_if.req_valid  = 1'b0;
    req_if.req_target = ~tgt;
    step();
    chk("wait_s", {24'h0, s_out}, 32'h0);
    chk("wait_r", {24'h0, r_out}, 32'h0);
    chk("wait_done", {31'h0, done}, 32'h0);
    step();
    chk("check_done", {31'h0, done}, 32'h0);
    step();
    chk("done", {31'h0, done}, 32'h1);
    chk("done_err", {31'h0, err}, 32'h0);
    chk("done_q", {24'h0, q_fb}, {24'h0, tgt});
    chk("done_busy", {31'h0, busy}, 32'h0);
    chk("done_ready", {31'h0, req_if.req_ready}, 32'h1);
    step();
    chk("done_pulse", {31'h0, done}, 32'h0);
  endtask

  initial begin
    req_if.req_valid  = 1'b0;
    req_if.req_target = 8'h00;
    bank_ld     = 1'b1;
    bank_ld_val = 8'h00;
    #2 rst_n = 1'b0;
    step();
    step();
    bank_ld = 1'b0;
    chk("rst_s", {24'h0, s_out}, 32'h0);
    chk("rst_r", {24'h0, r_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'h0, req_if.req_ready}, 32'h1);
`ifdef SR_EXCITE_STATS_EN
    chk("rst_stats", {24'h0, retry_total}, 32'h0);
`endif

    // 1: set-only excitation from an all-zero bank
    run_req(8'hA5, 8'hA5, 8'h00);
    // 2: mixed set/reset
    preload(8'hF0);
    run_req(8'h3C, 8'h0C, 8'hC0);
    // 3: target already held, memory-hold drive
    preload(8'h5A);
    run_req(8'h5A, 8'h00, 8'h00);

    // 4: bit0 stuck low, retries exhausted
    preload(8'h00);
    stuck0 = 8'h01;
    req_if.req_valid  = 1'b1;
    req_if.req_target = 8'h01;
    step();
    req_if.req_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      chk("retry_drive_s", {24'h0, s_out}, 32'h01);
      chk("retry_drive_r", {24'h0, r_out}, 32'h00);
      chk("retry_drive_busy", {31'h0, busy}, 32'h1);
      step();
      chk("retry_wait_s", {24'h0, s_out}, 32'h0);
      chk("retry_wait_busy", {31'h0, busy}, 32'h1);
      step();
      chk("retry_check_busy", {31'h0, busy}, 32'h1);
      chk("retry_no_done", {31'h0, done}, 32'h0);
      chk("retry_no_err", {31'h0, err}, 32'h0);
      step();
    end
    chk("err_pulse", {31'h0, err}, 32'h1);
    chk("err_no_done", {31'h0, done}, 32'h0);
    chk("err_busy", {31'h0, busy}, 32'h0);
`ifdef SR_EXCITE_STATS_EN
    chk("stats_retry_total", {24'h0, retry_total}, 32'h3);
`endif
    step();
    chk("err_pulse_end", {31'h0, err}, 32'h0);
    stuck0 = 8'h00;
    preload(8'h00);

    // 5: async reset in the middle of DRIVE
    req_if.req_valid  = 1'b1;
    req_if.req_target = 8'hFF;
    step();
    req_if.req_valid = 1'b0;
    chk("abort_drive_s", {24'h0, s_out}, 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("abort_s", {24'h0, s_out}, 32'h0);
    chk("abort_r", {24'h0, r_out}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", {31'h0, done}, 32'h0);
      chk("abort_no_err", {31'h0, err}, 32'h0);
      chk("abort_ready", {31'h0, req_if.req_ready}, 32'h1);
    end
    chk("abort_bank_q", {24'h0, q_fb}, 32'h00);

    // 6: back-to-back requests with req_valid held high
    req_if.req_valid  = 1'b1;
    req_if.req_target = 8'h0F;
    step();
    chk("b2b_first_s", {24'h0, s_out}, 32'h0F);
    chk("b2b_first_r", {24'h0, r_out}, 32'h00);
    req_if.req_target = 8'hF0;
    step();
    step();
    step();
    chk("b2b_first_done", {31'h0, done}, 32'h1);
    chk("b2b_first_q", {24'h0, q_fb}, 32'h0F);
    chk("b2b_ready_in_done", {31'h0, req_if.req_ready}, 32'h1);
    step();
    req_if.req_valid = 1'b0;
    chk("b2b_second_s", {24'h0, s_out}, 32'hF0);
    chk("b2b_second_r", {24'h0, r_out}, 32'h0F);
    chk("b2b_second_busy", {31'h0, busy}, 32'h1);
    chk("b2b_second_no_done", {31'h0, done}, 32'h0);
    step();
    step();
    chk("b2b_second_early", {31'h0, done}, 32'h0);
    step();
    chk("b2b_second_done", {31'h0, done}, 32'h1);
    chk("b2b_second_q", {24'h0, q_fb}, 32'hF0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
